// File: rtl/instr_fetch_unit_pkg.sv
// Shared fetch-stage types and constants: state encoding, reset defaults and
// the opcode values the main control decoder also uses.
package instr_fetch_unit_pkg;

  localparam int          DEF_XLEN      = 32;
  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_RTYPE  = 7'b011_0011;
  localparam logic [6:0] OPC_IALU   = 7'b001_0011;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;

  typedef enum logic [1:0] {
    ST_REQ   = 2'd0,
    ST_VALID = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read channel: a req/ack word read that tolerates wait states.
interface instr_fetch_unit_if #(parameter int XLEN = 32);
  logic            req;
  logic [XLEN-1:0] addr;
  logic            ack;
  logic [XLEN-1:0] rdata;

  modport master (output req, output addr, input ack, input rdata);
  modport slave  (input req, input addr, output ack, output rdata);
endinterface

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// Next-PC selection for a retiring instruction: sequential or branch target,
// plus detection of a taken branch to a non-word-aligned target.
module pc_next_sel
  import instr_fetch_unit_pkg::*;
#(
  parameter int XLEN = DEF_XLEN
) (
  input  logic [XLEN-1:0] pc,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] next_pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            misalign
);

  // Wraps silently at the top of the address space.
  assign pc_plus4 = pc + XLEN'(4);
  assign next_pc  = branch_taken ? branch_target : pc_plus4;
  assign misalign = branch_taken && (branch_target[1:0] != 2'b00);

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory over req/ack and holds the
// fetched word for decode/execute until it retires.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              XLEN      = DEF_XLEN,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(DEF_RESET_PC),
  parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(DEF_NOP_INSTR)
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_fetch_unit_if.master  imem,
  input  logic                stall_i,
  input  logic                branch_taken,
  input  logic [XLEN-1:0]     branch_target,
  output logic [XLEN-1:0]     instr,
  output logic [XLEN-1:0]     pc,
  output logic [XLEN-1:0]     pc_plus4,
  output logic                instr_valid,
  output logic                misalign_err
);

  fetch_state_t    state;
  logic [XLEN-1:0] next_pc;
  logic            misalign;

  pc_next_sel #(.XLEN(XLEN)) u_pc_next_sel (
    .pc            (pc),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .next_pc       (next_pc),
    .pc_plus4      (pc_plus4),
    .misalign      (misalign)
  );

  // NOTE: reset is synchronous, so the state is already REQ while rst_n is low;
  // gating with rst_n keeps the request quiet until reset is released.
  assign imem.req  = rst_n && (state == ST_REQ);
  assign imem.addr = pc;

  // NOTE: non-blocking assignments throughout, so every register sees the
  // pre-edge values of the others regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ST_REQ;
      pc           <= RESET_PC;
      instr        <= NOP_INSTR;
      instr_valid  <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        ST_REQ: begin
          if (imem.ack) begin
            instr       <= imem.rdata;
            instr_valid <= 1'b1;
            state       <= ST_VALID;
          end
        end
        ST_VALID: begin
          if (!stall_i) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
            pc          <= next_pc;
            if (misalign) begin
              misalign_err <= 1'b1;
              state        <= ST_HALT;
            end else begin
              state <= ST_REQ;
            end
          end
        end
        ST_HALT: ;
        default: state <= ST_HALT;
      endcase
    end
  end

endmodule
